// File: rtl/axi_load_sequencer.sv
// Arbitrates three load masters onto one AXI read channel and steers R beats back to the owner.
// Optional macro ROUND_ROBIN_EN selects rotating priority; otherwise fixed m0 > m1 > m2.
module axi_load_sequencer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            m_req,
  input  logic [3*ADDR_W-1:0]   m_addr,
  input  logic [3*LEN_W-1:0]    m_len,
  output logic [2:0]            m_rvalid,
  output logic [DATA_W-1:0]     m_rdata,
  output logic                  m_rlast,
  output logic [2:0]            m_done,
  output logic                  m_err,
  output logic                  busy,
  output logic [3:0]            arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [LEN_W-1:0]      arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t             state_q;
  logic [1:0]         owner_q, last_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q, cnt_q;
  logic               err_q, arvalid_q, rready_q, busy_q, m_err_q;
  logic [2:0]         done_q;

  logic [1:0]         start, cand, win;
  logic [2:0]         sum;
  logic               found;
  logic               match, beat_ok, beat_bad, beat_err;

  always_comb begin
`ifdef ROUND_ROBIN_EN
    start = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
`else
    start = 2'd0;
`endif
    found = 1'b0;
    win   = 2'd0;
    cand  = 2'd0;
    sum   = 3'd0;
    for (int unsigned k = 0; k < 3; k++) begin
      sum  = {1'b0, start} + 3'(k);
      cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!found && m_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign match    = (rid[1:0] == owner_q);
  assign beat_ok  = rready_q && rvalid && match;
  assign beat_bad = rready_q && rvalid && !match;
  // A matching beat is wrong if rlast disagrees with the latched length.
  assign beat_err = (rresp != 2'b00) || (rlast ? (cnt_q != len_q) : (cnt_q == len_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 2'd0;
      last_q    <= 2'd2;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= '0;
      m_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            owner_q   <= win;
            addr_q    <= m_addr[32'(win)*ADDR_W +: ADDR_W];
            len_q     <= m_len[32'(win)*LEN_W +: LEN_W];
            cnt_q     <= '0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (beat_ok) begin
            cnt_q <= cnt_q + 1'b1;
            err_q <= err_q | beat_err;
            if (rlast) begin
              rready_q <= 1'b0;
              done_q   <= 3'b001 << owner_q;
              m_err_q  <= err_q | beat_err;
              state_q  <= DONE;
            end
          end else if (beat_bad) begin
            err_q <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= '0;
          m_err_q <= 1'b0;
          busy_q  <= 1'b0;
          last_q  <= owner_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_rvalid = beat_ok ? (3'b001 << owner_q) : '0;
  assign m_rdata  = beat_ok ? rdata : '0;
  assign m_rlast  = beat_ok && rlast;
  assign m_done   = done_q;
  assign m_err    = m_err_q;
  assign busy     = busy_q;
  assign arid     = {2'b00, owner_q};
  assign araddr   = addr_q;
  assign arlen    = len_q;
  assign arsize   = 3'($clog2(DATA_W/8));
  assign arburst  = 2'b01;
  assign arvalid  = arvalid_q;
  assign rready   = rready_q;

  logic unused_bits;
  assign unused_bits = ^{rid[3:2], last_q};

endmodule

// File: tb/tb_axi_load_sequencer.sv
// Directed bench for axi_load_sequencer; inputs driven and outputs sampled around the falling edge.
module tb_axi_load_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  m_req;
  logic [95:0] m_addr;
  logic [23:0] m_len;
  logic [2:0]  m_rvalid;
  logic [31:0] m_rdata;
  logic        m_rlast;
  logic [2:0]  m_done;
  logic        m_err;
  logic        busy;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_cmp = 0;
  int n_err = 0;

  axi_load_sequencer #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_addr(m_addr), .m_len(m_len),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_done(m_done),
    .m_err(m_err), .busy(busy), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic set_req(input logic [1:0] m, input logic [31:0] a, input logic [7:0] l);
    m_addr[32'(m)*32 +: 32] = a;
    m_len[32'(m)*8 +: 8]    = l;
    m_req[m]                = 1'b1;
  endtask

  // Called at a falling edge with the request already driven; ends on the idle cycle after DONE.
  task automatic run_txn(input logic [1:0] own, input logic [31:0] addr, input logic [7:0] len,
                         input int nbeats, input int bad_beat, input bit foreign,
                         input int ar_delay, input bit exp_err, input bit drop_req);
    int w = 0;
    logic [31:0] d;
    while (!arvalid && w < 8) begin
      step;
      w++;
    end
    check("ar_latency", 64'(w), 64'd1);
    check("busy_grant", 64'(busy), 64'd1);
    check("araddr", 64'(araddr), 64'(addr));
    check("arlen", 64'(arlen), 64'(len));
    check("arid", 64'(arid), 64'({2'b00, own}));
    for (int i = 0; i < ar_delay; i++) begin
      arready = 1'b0;
      step;
      check("arvalid_hold", 64'(arvalid), 64'd1);
      check("araddr_hold", 64'({arid, arlen, araddr}), 64'({2'b00, own, len, addr}));
    end
    arready = 1'b1;
    step;
    arready = 1'b0;
    check("arvalid_drop", 64'(arvalid), 64'd0);
    check("rready_data", 64'(rready), 64'd1);
    if (foreign) begin
      rvalid = 1'b1; rid = {2'b00, own ^ 2'b01}; rdata = 32'hBAD0_0000; rresp = 2'b00; rlast = 1'b1;
      #1;
      check("foreign_rvalid", 64'(m_rvalid), 64'd0);
      step;
    end
    for (int b = 0; b < nbeats; b++) begin
      d = 32'hD000_0000 | (32'(own) << 8) | 32'(b);
      rvalid = 1'b1; rid = {2'b00, own}; rdata = d;
      rresp = (b == bad_beat) ? 2'b10 : 2'b00;
      rlast = (b == nbeats - 1);
      if (drop_req && b == 0) begin
        m_req[own] = 1'b0;
        set_req(2'd0, 32'h0000_5000, 8'd0);
      end
      #1;
      check("m_rvalid", 64'(m_rvalid), 64'(3'b001 << own));
      check("m_rdata", 64'(m_rdata), 64'(d));
      check("m_rlast", 64'(m_rlast), 64'(b == nbeats - 1));
      step;
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    m_req[own] = 1'b0;
    check("m_done", 64'(m_done), 64'(3'b001 << own));
    check("m_err", 64'(m_err), 64'(exp_err));
    check("busy_done", 64'(busy), 64'd1);
    check("rready_done", 64'(rready), 64'd0);
    step;
    check("m_done_clear", 64'(m_done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; m_req = '0; m_addr = '0; m_len = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    #1;
    check("rst_outputs", 64'({m_rvalid, m_done, m_err, busy, arvalid, rready, m_rlast}), 64'd0);
    check("rst_ar", 64'({arid, araddr, arlen}), 64'd0);
    check("rst_arsize", 64'(arsize), 64'd2);
    check("rst_arburst", 64'(arburst), 64'd1);
    step;
    rst_n = 1'b1;
    step;

    // single read, 4 beats
    set_req(2'd0, 32'h0000_1000, 8'd3);
    run_txn(2'd0, 32'h0000_1000, 8'd3, 4, -1, 1'b0, 0, 1'b0, 1'b0);

    // contention, each len 0
    set_req(2'd0, 32'h0000_0100, 8'd0);
    set_req(2'd1, 32'h0000_0200, 8'd0);
    set_req(2'd2, 32'h0000_0300, 8'd0);
    run_txn(2'd0, 32'h0000_0100, 8'd0, 1, -1, 1'b0, 0, 1'b0, 1'b0);
`ifdef ROUND_ROBIN_EN
    m_req[0] = 1'b1;
`endif
    run_txn(2'd1, 32'h0000_0200, 8'd0, 1, -1, 1'b0, 0, 1'b0, 1'b0);
    run_txn(2'd2, 32'h0000_0300, 8'd0, 1, -1, 1'b0, 0, 1'b0, 1'b0);
`ifdef ROUND_ROBIN_EN
    run_txn(2'd0, 32'h0000_0100, 8'd0, 1, -1, 1'b0, 0, 1'b0, 1'b0);
`endif

    // AR backpressure for 5 cycles
    set_req(2'd1, 32'h0000_3000, 8'd1);
    run_txn(2'd1, 32'h0000_3000, 8'd1, 2, -1, 1'b0, 5, 1'b0, 1'b0);

    // bad rresp on beat 2 of 4
    set_req(2'd0, 32'h0000_4000, 8'd3);
    run_txn(2'd0, 32'h0000_4000, 8'd3, 4, 1, 1'b0, 0, 1'b1, 1'b0);

    // early rlast on beat 2 with len 3
    set_req(2'd2, 32'h0000_4100, 8'd3);
    run_txn(2'd2, 32'h0000_4100, 8'd3, 2, -1, 1'b0, 0, 1'b1, 1'b0);

    // foreign rid beat discarded and flagged
    set_req(2'd1, 32'h0000_4200, 8'd0);
    run_txn(2'd1, 32'h0000_4200, 8'd0, 1, -1, 1'b1, 0, 1'b1, 1'b0);

    // m2 drops its request mid-burst while m0 starts requesting
    set_req(2'd2, 32'h0000_6000, 8'd1);
    run_txn(2'd2, 32'h0000_6000, 8'd1, 2, -1, 1'b0, 0, 1'b0, 1'b1);
    run_txn(2'd0, 32'h0000_5000, 8'd0, 1, -1, 1'b0, 0, 1'b0, 1'b0);

    // reset in the middle of DATA
    set_req(2'd0, 32'h0000_7000, 8'd3);
    step;
    check("rst_test_arvalid", 64'(arvalid), 64'd1);
    arready = 1'b1;
    step;
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h1111_0000; rlast = 1'b0;
    step;
    rdata = 32'h1111_0001;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", 64'({arvalid, rready, busy, m_rvalid, m_done}), 64'd0);
    m_req = '0; rvalid = 1'b0;
    step;
    rst_n = 1'b1;
    step;
    check("post_rst_done", 64'(m_done), 64'd0);
    set_req(2'd1, 32'h0000_8000, 8'd1);
    run_txn(2'd1, 32'h0000_8000, 8'd1, 2, -1, 1'b0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_load_sequencer.md
Name: axi_load_sequencer

Overview:
Sequences the shared AXI read (load) channel between three masters: m0 data, m1 instruction, m2 uncached/peripheral.
- Picks one requester and latches its address and burst length.
- Drives the AR handshake, collects R beats and steers them to the owner.
- Releases the bus only after the last beat.
- Sits between the cache-side load requesters and the top-level AXI interface.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; arsize = log2(DATA_W/8)
LEN_W, 8, burst length field width (beats-1, AXI4 arlen)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
m_req  in  3  per-master request, bit i = master i; held high until m_done[i]
m_addr  in  3*ADDR_W  per-master start address, slice i
m_len  in  3*LEN_W  per-master beats-1, slice i
m_rvalid  out  3  one-hot beat strobe to the owner
m_rdata  out  DATA_W  beat data, shared by all masters
m_rlast  out  1  qualifies final beat, valid with m_rvalid
m_done  out  3  one-cycle completion pulse to the owner
m_err  out  1  valid with m_done; 1 = bad rresp or beat-count mismatch
busy  out  1  high from grant to end of DONE
arid  out  4  {2'b00, owner}
araddr  out  ADDR_W  latched address
arlen  out  LEN_W  latched length
arsize  out  3  constant log2(DATA_W/8)
arburst  out  2  constant 2'b01 (INCR)
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  read id
rdata  in  DATA_W  read data
rresp  in  2  read response
rlast  in  1  read last
rvalid  in  1  read valid
rready  out  1  read ready

Behaviour:
Reset:
- rst_n low (async) forces state IDLE and owner 0.
- All outputs 0, except the constants arsize and arburst.
- Beat counter 0, error flag 0, last-owner 2.
- Reset mid-transaction abandons it; no m_done is issued.

State IDLE:
- If m_req != 0, select a winner per the priority rule.
- Latch owner, m_addr slice, m_len slice; clear beat count and error flag.
- Go to ADDR.
- busy rises on the same edge; arvalid is high in the cycle after req is seen.

State ADDR:
- arvalid = 1; araddr, arlen, arid stay stable until arvalid && arready.
- On the handshake go to DATA.
- arready already high on the first ADDR cycle completes the handshake in one cycle.

State DATA:
- rready = 1.
- Each cycle with rvalid && rid[1:0] == owner:
  - m_rvalid[owner] = 1 (combinational) and m_rdata = rdata.
  - Beat count increments, wrapping at LEN_W bits.
  - Any rresp != 2'b00 sets the error flag.
- Beats with a non-matching rid are accepted (rready stays 1), discarded, and set the error flag.
- On a matching beat with rlast: m_rlast = 1.
  - If the beat count != latched len, set the error flag.
  - Go to DONE.
- A matching beat where beat count == len but rlast = 0 sets the error flag and stays in DATA until rlast.

State DONE (one cycle):
- m_done[owner] = 1, m_err = flag, busy = 1, rready = 0.
- Record last-owner = owner; go to IDLE.
- A new request is arbitrated in the following IDLE cycle, so there is a minimum 1 idle cycle between transactions.

Request rules:
- m_req[owner] dropping mid-transaction does not abort; the burst completes and m_done still pulses.
- Changes on other masters' m_addr/m_len while busy are ignored.

Fixed-priority rule (macro absent): m0 > m1 > m2.

Minimum latency, len = 0, arready and rvalid immediate: req at cycle 0, arvalid at cycle 1, beat at cycle 2, m_done at cycle 3.

Optional Feature:
ROUND_ROBIN_EN
- Defined: rotating priority. Search starts at (last-owner + 1) mod 3. From reset, last-owner = 2, so the first search order is m0, m1, m2.
- Undefined: fixed priority m0 > m1 > m2; last-owner is still tracked but unused.

Test Plan:
- Single read: m_req = 3'b001, m0_addr = 0x1000, len = 3, arready at once, 4 beats, rlast on the 4th -> araddr = 0x1000, arlen = 3, arid = 0; m_rvalid[0] pulses 4x; m_done = 3'b001, m_err = 0 one cycle after the last beat.
- Contention: m_req = 3'b111 at once, each len = 0.
  - Fixed priority: grant order m0, m1, m2.
  - ROUND_ROBIN_EN with m0 re-requesting after done: order m0, m1, m2, m0.
  - In both cases busy drops for exactly 1 cycle between transactions.
- AR backpressure: arready low for 5 cycles -> arvalid high for 6 cycles with araddr/arlen/arid constant, accepted on cycle 6.
- Errors:
  - rresp = 2'b10 on beat 2 of 4 -> all 4 beats delivered, m_err = 1 with m_done.
  - rlast on beat 2 with len = 3 -> m_err = 1, return to IDLE.
- Reset mid-DATA: rst_n low after beat 1 -> arvalid, rready, busy, m_rvalid, m_done all 0 immediately (async); after release, a fresh m1 request completes normally.
- Request drop: m2 drops m_req during DATA, len = 1 -> both beats strobe m_rvalid[2], m_done[2] pulses, no other master is granted before DONE.
